// File: rtl/image_sobel_gradient.sv
// image_sobel_gradient: 3x3 Sobel magnitude |gx|+|gy| and 4-bin direction over a pixel stream
module image_sobel_gradient #(
  parameter int IMG_WIDTH  = 640,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [DATA_WIDTH-1:0] per_img_gray,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic                  post_frame_clken,
  output logic [DATA_WIDTH+2:0] post_img_mag,
  output logic [1:0]            post_img_dir
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int SW = DATA_WIDTH + 2;
  localparam int GW = DATA_WIDTH + 3;
  localparam int PW = GW + 9;
  logic [CW-1:0] col_cnt;
  logic [9:0] row_cnt;
  logic href_d, vsync_d;
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [SW-1:0] sr, sl, sb, st;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0] ax, ay;
  logic sx, sy, v1, v2, v3;
  logic [PW-1:0] a53, a309, b128;
  logic [1:0] dir_n;
  logic [11:0] ctl_sr;
  wire href_fall  = href_d & ~per_frame_href;
  wire vsync_rise = per_frame_vsync & ~vsync_d;
  assign gx = $signed({1'b0, sr}) - $signed({1'b0, sl});
  assign gy = $signed({1'b0, sb}) - $signed({1'b0, st});
  assign a53  = PW'(ax) * PW'(53);
  assign a309 = PW'(ax) * PW'(309);
  assign b128 = PW'(ay) << 7;
  assign dir_n = (b128 <= a53) ? 2'd0 : (b128 >= a309) ? 2'd2 : (sx == sy) ? 2'd1 : 2'd3;
  assign {post_frame_vsync, post_frame_href, post_frame_clken} = ctl_sr[11:9];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d  <= 1'b0;
      vsync_d <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      href_d  <= per_frame_href;
      vsync_d <= per_frame_vsync;
      if (href_fall) col_cnt <= '0;
      else if (per_frame_clken && col_cnt != CW'(IMG_WIDTH - 1)) col_cnt <= col_cnt + 1'b1;
      if (vsync_rise) row_cnt <= '0;
      else if (href_fall && row_cnt != 10'd1023) row_cnt <= row_cnt + 1'b1;
    end
  end
  // Line buffer RAM is deliberately unreset; the border flag hides stale rows.
  always_ff @(posedge clk) begin
    if (per_frame_clken) begin
      lb1[col_cnt] <= per_img_gray;
      lb2[col_cnt] <= lb1[col_cnt];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
      {sr, sl, sb, st} <= '0;
      {ax, ay, sx, sy, v1, v2, v3} <= '0;
      post_img_mag <= '0;
      post_img_dir <= '0;
      ctl_sr <= '0;
    end else begin
      if (per_frame_clken) begin
        {p11, p12, p13} <= {p12, p13, lb2[col_cnt]};
        {p21, p22, p23} <= {p22, p23, lb1[col_cnt]};
        {p31, p32, p33} <= {p32, p33, per_img_gray};
        v1 <= (row_cnt >= 10'd2) && (col_cnt >= CW'(2));
      end
      sr <= SW'(p13) + (SW'(p23) << 1) + SW'(p33);
      sl <= SW'(p11) + (SW'(p21) << 1) + SW'(p31);
      sb <= SW'(p31) + (SW'(p32) << 1) + SW'(p33);
      st <= SW'(p11) + (SW'(p12) << 1) + SW'(p13);
      v2 <= v1;
      ax <= gx[GW-1] ? GW'(-gx) : GW'(gx);
      ay <= gy[GW-1] ? GW'(-gy) : GW'(gy);
      sx <= gx[GW-1];
      sy <= gy[GW-1];
      v3 <= v2;
      post_img_mag <= v3 ? ax + ay : '0;
      post_img_dir <= v3 ? dir_n : 2'd0;
      ctl_sr <= {ctl_sr[8:0], per_frame_vsync, per_frame_href, per_frame_clken};
    end
  end
endmodule

// File: tb/tb_image_sobel_gradient.sv
// tb_image_sobel_gradient: directed frames checked against hand-derived values and a spatial Sobel model
module tb_image_sobel_gradient;
  logic clk = 1'b0, rst_n = 1'b0, vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [7:0] gray = '0;
  logic post_vs, post_hr, post_ce;
  logic [10:0] mag;
  logic [1:0] dir;
  logic [11:0] hist = '0;
  logic [7:0] img [8][640];
  int q_mag[$], q_dir[$];
  int ctl_err = 0, n_cmp = 0, n_err = 0, w = 8, h = 8;

  image_sobel_gradient dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_gray(gray),
    .post_frame_vsync(post_vs), .post_frame_href(post_hr), .post_frame_clken(post_ce),
    .post_img_mag(mag), .post_img_dir(dir)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) hist <= '0;
    else hist <= {hist[8:0], vs, hr, ce};

  always @(negedge clk) begin
    if ({post_vs, post_hr, post_ce} !== hist[11:9]) ctl_err++;
    if (post_ce) begin
      q_mag.push_back(int'(mag));
      q_dir.push_back(int'(dir));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int r, input int c);
    return int'(img[r][c]);
  endfunction

  function automatic void gold(input int r, input int c, output int m, output int d);
    int gx, gy, ax, ay;
    m = 0;
    d = 0;
    if (r < 2 || c < 2) return;
    gx = (px(r-2,c) + 2*px(r-1,c) + px(r,c)) - (px(r-2,c-2) + 2*px(r-1,c-2) + px(r,c-2));
    gy = (px(r,c-2) + 2*px(r,c-1) + px(r,c)) - (px(r-2,c-2) + 2*px(r-2,c-1) + px(r-2,c));
    ax = gx < 0 ? -gx : gx;
    ay = gy < 0 ? -gy : gy;
    m = ax + ay;
    d = (128*ay <= 53*ax) ? 0 : (128*ay >= 309*ax) ? 2 : ((gx < 0) == (gy < 0)) ? 1 : 3;
  endfunction

  // Hand-derived expectations per test; test 7 defers to the spatial model.
  function automatic void expect_px(input int t, input int r, input int c, output int m, output int d);
    m = 0;
    d = 0;
    if (t == 7) gold(r, c, m, d);
    else if (r >= 2 && c >= 2)
      case (t)
        3: m = (c-2 == 6 || c-2 == 7) ? 800 : 0;
        4: begin m = (r-2 == 2 || r-2 == 3) ? 800 : 0; d = m != 0 ? 2 : 0; end
        5: begin m = 160; d = 1; end
        6: begin m = 160; d = 3; end
        default: ;
      endcase
  endfunction

  task automatic drive_frame(input bit gaps);
    vs = 1'b1;
    repeat (2) tick();
    vs = 1'b0;
    repeat (2) tick();
    for (int r = 0; r < h; r++) begin
      hr = 1'b1;
      for (int c = 0; c < w; c++) begin
        if (gaps) while ($urandom_range(0, 1) == 1) begin ce = 1'b0; tick(); end
        ce = 1'b1;
        gray = img[r][c];
        tick();
      end
      ce = 1'b0;
      hr = 1'b0;
      repeat (3) tick();
    end
    repeat (8) tick();
  endtask

  task automatic run_frame(input int t, input string tag, input bit gaps);
    int base, m, d;
    base = q_mag.size();
    drive_frame(gaps);
    chk({tag, "_count"}, q_mag.size() - base, w*h);
    chk({tag, "_ctl_delay"}, ctl_err, 0);
    if (q_mag.size() - base >= w*h)
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          expect_px(t, r, c, m, d);
          chk($sformatf("%s_mag_r%0d_c%0d", tag, r, c), q_mag[base + r*w + c], m);
          chk($sformatf("%s_dir_r%0d_c%0d", tag, r, c), q_dir[base + r*w + c], d);
        end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_init_href", int'(post_hr), 0);
    chk("rst_init_mag", int'(mag), 0);
    rst_n = 1'b1;
    tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    hr = 1'b1;
    ce = 1'b1;
    gray = 8'd50;
    repeat (6) tick();
    chk("pre_rst_href", int'(post_hr), 1);
    chk("pre_rst_clken", int'(post_ce), 1);
    #2 rst_n = 1'b0;
    hr = 1'b0;
    ce = 1'b0;
    gray = '0;
    #1;
    chk("rst_vsync", int'(post_vs), 0);
    chk("rst_href", int'(post_hr), 0);
    chk("rst_clken", int'(post_ce), 0);
    chk("rst_mag", int'(mag), 0);
    chk("rst_dir", int'(dir), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rst_hold_%0d", i), int'({post_vs, post_hr, post_ce, mag, dir}), 0);
    end
    w = 8; h = 8;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 8'd100;
    run_frame(2, "flat", 1'b0);
    w = 16;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 16; c++) img[r][c] = c < 8 ? 8'd0 : 8'd200;
    run_frame(3, "vstep", 1'b0);
    w = 8;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = r < 4 ? 8'd0 : 8'd200;
    run_frame(4, "hstep", 1'b0);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 8'(10*(r+c));
    run_frame(5, "diag45", 1'b0);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 8'(10*(c-r+7));
    run_frame(6, "diag135", 1'b0);
    w = 640; h = 4;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 640; c++) img[r][c] = 8'($urandom_range(0, 255));
    run_frame(7, "rand", 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
